muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer_pkg.sv | 36 +++
 rtl/muldiv_sequencer_if.sv | 32 +++
 rtl/muldiv_sequencer_divider_core.sv | 53 +++++
 rtl/muldiv_sequencer.sv | 165 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// ============================================================================
// Module      : mext_pkg
// Description : Shared M-extension opcodes, sequencer state encoding, XLEN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mext_pkg;

    localparam int XLEN = 32;

    // Opcodes shared with the control unit
    localparam logic [4:0] c_OP_MUL    = 5'b01000;
    localparam logic [4:0] c_OP_MULH   = 5'b01001;
    localparam logic [4:0] c_OP_MULHU  = 5'b01010;
    localparam logic [4:0] c_OP_MULHSU = 5'b01011;
    localparam logic [4:0] c_OP_DIV    = 5'b01100;
    localparam logic [4:0] c_OP_DIVU   = 5'b01101;
    localparam logic [4:0] c_OP_REM    = 5'b01110;
    localparam logic [4:0] c_OP_REMU   = 5'b01111;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_WAIT = 3'd1,
        S_DIV_ITER = 3'd2,
        S_DIV_FIX  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    function automatic logic is_mop(input logic [4:0] op);
        return op[4:3] == 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_sequencer_if.sv
// ============================================================================
// Module      : muldiv_sequencer_if
// Description : EX-stage <-> multiply/divide sequencer handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_sequencer_if #(
    parameter int XLEN = mext_pkg::XLEN
);
    logic            START;
    logic [4:0]      ALU_OPCODE;
    logic [XLEN-1:0] OPERAND1;
    logic [XLEN-1:0] OPERAND2;
    logic            FLUSH;
    logic            STALL;
    logic            BUSY;
    logic [XLEN-1:0] RESULT;
    logic            RESULT_VALID;

    modport master (
        output START, ALU_OPCODE, OPERAND1, OPERAND2, FLUSH,
        input  STALL, BUSY, RESULT, RESULT_VALID
    );

    modport slave (
        input  START, ALU_OPCODE, OPERAND1, OPERAND2, FLUSH,
        output STALL, BUSY, RESULT, RESULT_VALID
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_sequencer_divider_core.sv
// ============================================================================
// Module      : divider_core
// Description : Unsigned restoring divider, one quotient bit per step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_core #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_step,
    input  wire logic [WIDTH-1:0] i_dividend,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH-1:0] o_quotient,
    output logic      [WIDTH-1:0] o_remainder
);

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    // The dividend is shifted out of the quotient register as quotient bits fill in
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_fits  = !w_diff[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (i_load) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_div <= i_divisor;
        end else if (i_step) begin
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
            r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module      : muldiv_sequencer
// Description : Multi-cycle RV32M sequencer: registered multiply, 32-step divide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
    parameter int XLEN      = mext_pkg::XLEN,
    parameter int DIV_STEPS = XLEN
) (
    input  wire logic         CLK,
    input  wire logic         RESET,
    muldiv_sequencer_if.slave bus
);
    import mext_pkg::*;

    localparam int                 c_CNT_W    = $clog2(DIV_STEPS);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(DIV_STEPS - 1);
    localparam logic [XLEN-1:0]    c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t               r_state, w_state_next;
    logic [2:0]           r_func;
    logic [XLEN-1:0]      r_op1, r_op2, r_result;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_div_zero, r_div_ovf, r_q_neg, r_r_neg;

    logic                 w_accept, w_is_mul, w_is_sdiv, w_div_zero, w_div_ovf;
    logic                 w_load, w_step, w_load_result, w_stall, w_valid;
    logic [XLEN-1:0]      w_mag1, w_mag2, w_quo, w_rem, w_result_next;
    logic                 w_a_ext, w_b_ext;
    logic [2*XLEN-1:0]    w_mul_a, w_mul_b, w_prod;

    assign w_accept   = bus.START && is_mop(bus.ALU_OPCODE) && !bus.FLUSH && (r_state == S_IDLE);
    assign w_is_mul   = !bus.ALU_OPCODE[2];
    assign w_is_sdiv  = !bus.ALU_OPCODE[0];
    assign w_div_zero = (bus.OPERAND2 == '0);
    assign w_div_ovf  = w_is_sdiv && (bus.OPERAND1 == c_MIN_NEG) && (bus.OPERAND2 == '1);
    assign w_mag1     = (w_is_sdiv && bus.OPERAND1[XLEN-1]) ? -bus.OPERAND1 : bus.OPERAND1;
    assign w_mag2     = (w_is_sdiv && bus.OPERAND2[XLEN-1]) ? -bus.OPERAND2 : bus.OPERAND2;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_load        = 1'b0;
        w_step        = 1'b0;
        w_load_result = 1'b0;
        w_stall       = 1'b0;
        w_valid       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stall = 1'b1;
                    w_load  = !w_is_mul;
                    if (w_is_mul)                     w_state_next = S_MUL_WAIT;
                    else if (w_div_zero || w_div_ovf) w_state_next = S_DIV_FIX;
                    else                              w_state_next = S_DIV_ITER;
                end
            end
            S_MUL_WAIT: begin
                w_stall = 1'b1;
                if (bus.FLUSH) w_state_next = S_IDLE;
                else begin
                    w_load_result = 1'b1;
                    w_state_next  = S_DONE;
                end
            end
            S_DIV_ITER: begin
                w_stall = 1'b1;
                if (bus.FLUSH) w_state_next = S_IDLE;
                else begin
                    w_step = 1'b1;
                    if (r_count == '0) w_state_next = S_DIV_FIX;
                end
            end
            S_DIV_FIX: begin
                w_stall = 1'b1;
                if (bus.FLUSH) w_state_next = S_IDLE;
                else begin
                    w_load_result = 1'b1;
                    w_state_next  = S_DONE;
                end
            end
            S_DONE: begin
                // Completion is already committed, so FLUSH cannot cancel it
                w_valid      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operands are extended to 2*XLEN so one unsigned multiply covers all sign modes
    assign w_a_ext = ((r_func == c_OP_MULH[2:0]) || (r_func == c_OP_MULHSU[2:0])) && r_op1[XLEN-1];
    assign w_b_ext = (r_func == c_OP_MULH[2:0]) && r_op2[XLEN-1];
    assign w_mul_a = {{XLEN{w_a_ext}}, r_op1};
    assign w_mul_b = {{XLEN{w_b_ext}}, r_op2};
    assign w_prod  = w_mul_a * w_mul_b;

    always_comb begin
        w_result_next = '0;
        if (!r_func[2]) begin
            w_result_next = (r_func[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end else if (r_div_zero) begin
            w_result_next = r_func[1] ? r_op1 : '1;
        end else if (r_div_ovf) begin
            w_result_next = r_func[1] ? '0 : c_MIN_NEG;
        end else if (r_func[1]) begin
            w_result_next = r_r_neg ? -w_rem : w_rem;
        end else begin
            w_result_next = r_q_neg ? -w_quo : w_quo;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_func     <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_count    <= '0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_result   <= '0;
        end else begin
            if (w_accept) begin
                r_func     <= bus.ALU_OPCODE[2:0];
                r_op1      <= bus.OPERAND1;
                r_op2      <= bus.OPERAND2;
                r_count    <= c_CNT_INIT;
                r_div_zero <= w_div_zero;
                r_div_ovf  <= w_div_ovf;
                r_q_neg    <= w_is_sdiv && (bus.OPERAND1[XLEN-1] ^ bus.OPERAND2[XLEN-1]);
                r_r_neg    <= w_is_sdiv && bus.OPERAND1[XLEN-1];
            end else if (w_step) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (w_load_result) r_result <= w_result_next;
        end
    end

    divider_core #(.WIDTH(XLEN)) u_divider_core (
        .clk         (CLK),
        .rst         (RESET),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_dividend  (w_mag1),
        .i_divisor   (w_mag2),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    assign bus.STALL        = w_stall;
    assign bus.BUSY         = (r_state != S_IDLE);
    assign bus.RESULT       = r_result;
    assign bus.RESULT_VALID = w_valid;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed-vector bench for muldiv_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;
    import mext_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 CLK = ~CLK;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge with the sequencer idle; returns at a negedge with it idle again
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int   lat;
        logic stall_ok;
        bus.START      = 1'b1;
        bus.ALU_OPCODE = op;
        bus.OPERAND1   = a;
        bus.OPERAND2   = b;
        #1 check({tag, "_stall_c0"}, {31'b0, bus.STALL}, 32'd1);
        @(negedge CLK);
        bus.START = 1'b0;
        lat       = 1;
        stall_ok  = 1'b1;
        while (!bus.RESULT_VALID && lat < 40) begin
            stall_ok &= bus.STALL;
            @(negedge CLK);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, bus.RESULT, exp_res);
        check({tag, "_stall_busy"}, {31'b0, stall_ok}, 32'd1);
        check({tag, "_stall_done"}, {31'b0, bus.STALL}, 32'd0);
        @(negedge CLK);
        check({tag, "_hold"}, bus.RESULT, exp_res);
        check({tag, "_valid_drop"}, {31'b0, bus.RESULT_VALID}, 32'd0);
    endtask

    initial begin
        logic valid_seen;
        RESET          = 1'b1;
        bus.START      = 1'b0;
        bus.FLUSH      = 1'b0;
        bus.ALU_OPCODE = '0;
        bus.OPERAND1   = '0;
        bus.OPERAND2   = '0;
        #1;
        check("rst_result", bus.RESULT, 32'h0);
        check("rst_valid", {31'b0, bus.RESULT_VALID}, 32'd0);
        check("rst_busy", {31'b0, bus.BUSY}, 32'd0);
        check("rst_stall", {31'b0, bus.STALL}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        run_op("mul",     c_OP_MUL,    32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 2);
        run_op("mulh",    c_OP_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        run_op("mulhu",   c_OP_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 2);
        run_op("mulhsu",  c_OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("div",     c_OP_DIV,    32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 34);
        run_op("rem",     c_OP_REM,    32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 34);
        run_op("divu",    c_OP_DIVU,   32'h0000_0014, 32'h0000_0003, 32'h0000_0006, 34);
        run_op("remu",    c_OP_REMU,   32'h0000_0014, 32'h0000_0003, 32'h0000_0002, 34);
        run_op("div_nd",  c_OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run_op("rem_nd",  c_OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34);
        run_op("divu_z",  c_OP_DIVU,   32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 2);
        run_op("rem_z",   c_OP_REM,    32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 2);
        run_op("div_ovf", c_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("rem_ovf", c_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

        // Flush a divide at cycle 10, then start a multiply right away
        bus.START      = 1'b1;
        bus.ALU_OPCODE = c_OP_DIV;
        bus.OPERAND1   = 32'd100;
        bus.OPERAND2   = 32'd7;
        @(negedge CLK);
        bus.START  = 1'b0;
        valid_seen = bus.RESULT_VALID;
        repeat (9) begin
            @(negedge CLK);
            valid_seen |= bus.RESULT_VALID;
        end
        bus.FLUSH = 1'b1;
        @(negedge CLK);
        bus.FLUSH = 1'b0;
        valid_seen |= bus.RESULT_VALID;
        check("flush_busy", {31'b0, bus.BUSY}, 32'd0);
        check("flush_no_valid", {31'b0, valid_seen}, 32'd0);
        check("flush_result_kept", bus.RESULT, 32'h0);
        run_op("mul_after_flush", c_OP_MUL, 32'd3, 32'd5, 32'h0000_000F, 2);

        // Asynchronous reset mid-divide
        bus.START      = 1'b1;
        bus.ALU_OPCODE = c_OP_DIV;
        bus.OPERAND1   = 32'd100;
        bus.OPERAND2   = 32'd7;
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (4) @(negedge CLK);
        check("pre_rst_busy", {31'b0, bus.BUSY}, 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("async_rst_busy", {31'b0, bus.BUSY}, 32'd0);
        check("async_rst_stall", {31'b0, bus.STALL}, 32'd0);
        check("async_rst_valid", {31'b0, bus.RESULT_VALID}, 32'd0);
        check("async_rst_result", bus.RESULT, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        run_op("div_after_rst", c_OP_DIV, 32'd100, 32'd7, 32'h0000_000E, 34);

        // Non-M opcode is ignored
        bus.START      = 1'b1;
        bus.ALU_OPCODE = 5'b00000;
        #1 check("nonm_stall", {31'b0, bus.STALL}, 32'd0);
        @(negedge CLK);
        check("nonm_busy", {31'b0, bus.BUSY}, 32'd0);

        // FLUSH together with START drops the start
        bus.ALU_OPCODE = c_OP_MUL;
        bus.FLUSH      = 1'b1;
        #1 check("flush_start_stall", {31'b0, bus.STALL}, 32'd0);
        @(negedge CLK);
        check("flush_start_busy", {31'b0, bus.BUSY}, 32'd0);
        bus.START = 1'b0;
        bus.FLUSH = 1'b0;
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
